// File: rtl/demux_stream_router.sv
// Packet router: locks a destination per packet and steers each beat to y0 or y1, one beat per cycle.
// Latency: one registered stage. Backpressure: in_ready drops while the held beat's consumer is not ready.
module demux_stream_router #(
    parameter int W       = 8,
    parameter bit RR_MODE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    input  logic         in_dest,
    output logic         y0_valid,
    input  logic         y0_ready,
    output logic [W-1:0] y0_data,
    output logic         y0_last,
    output logic         y1_valid,
    input  logic         y1_ready,
    output logic [W-1:0] y1_data,
    output logic         y1_last,
    output logic         busy,
    output logic         cur_sel,
    output logic [7:0]   pkt_cnt0,
    output logic [7:0]   pkt_cnt1
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PKT  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_out_valid;
    logic           r_out_sel;
    logic [W-1:0]   r_out_data;
    logic           r_out_last;
    logic           r_lock_sel;
    logic           r_rr_next;
    logic [7:0]     r_pkt_cnt0;
    logic [7:0]     r_pkt_cnt1;

    logic           w_hold_ok;
    logic           w_in_ready;
    logic           w_accept;
    logic           w_dest;
    logic           w_pkt_done;

    // The held beat can be replaced when it is empty or being drained this cycle.
    assign w_hold_ok  = ~r_out_valid | (r_out_sel ? y1_ready : y0_ready);
    assign w_accept   = in_valid & w_in_ready;
    assign w_pkt_done = w_accept & in_last;

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_dest      = r_lock_sel;
        case (r_state)
            S_IDLE: begin
                w_in_ready = en & w_hold_ok;
                w_dest     = RR_MODE ? r_rr_next : in_dest;
                if (in_valid && w_in_ready && !in_last) begin
                    w_state_nxt = S_PKT;
                end
            end
            S_PKT: begin
                w_in_ready = w_hold_ok;
                if (in_valid && w_in_ready && in_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sel   <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_sel   <= w_dest;
            r_out_data  <= in_data;
            r_out_last  <= in_last;
        end else if (w_hold_ok) begin
            r_out_valid <= 1'b0;
        end
    end

    // Destination is latched only on a first beat; counters move on input-side last beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_sel <= 1'b0;
            r_rr_next  <= 1'b0;
            r_pkt_cnt0 <= 8'd0;
            r_pkt_cnt1 <= 8'd0;
        end else begin
            if (w_accept && r_state == S_IDLE) begin
                r_lock_sel <= w_dest;
            end
            if (w_pkt_done) begin
                if (w_dest) begin
                    r_pkt_cnt1 <= r_pkt_cnt1 + 8'd1;
                end else begin
                    r_pkt_cnt0 <= r_pkt_cnt0 + 8'd1;
                end
                if (RR_MODE) begin
                    r_rr_next <= ~r_rr_next;
                end
            end
        end
    end

    assign in_ready = w_in_ready;
    assign y0_valid = r_out_valid & ~r_out_sel;
    assign y1_valid = r_out_valid &  r_out_sel;
    assign y0_data  = r_out_sel ? '0 : r_out_data;
    assign y1_data  = r_out_sel ? r_out_data : '0;
    assign y0_last  = ~r_out_sel & r_out_last;
    assign y1_last  =  r_out_sel & r_out_last;
    assign busy     = (r_state == S_PKT) | r_out_valid;
    assign cur_sel  = r_lock_sel;
    assign pkt_cnt0 = r_pkt_cnt0;
    assign pkt_cnt1 = r_pkt_cnt1;

endmodule

// File: tb/tb_demux_stream_router.sv
// Bench for demux_stream_router: instance 0 routes by in_dest, instance 1 alternates per packet.
// A packet-level reference model and per-port beat queues predict every output.
module tb_demux_stream_router;

    logic       clk;
    logic       rst_n;
    logic       en       [2];
    logic       in_valid [2];
    logic       in_ready [2];
    logic [7:0] in_data  [2];
    logic       in_last  [2];
    logic       in_dest  [2];
    logic       y0_valid [2];
    logic       y0_ready [2];
    logic [7:0] y0_data  [2];
    logic       y0_last  [2];
    logic       y1_valid [2];
    logic       y1_ready [2];
    logic [7:0] y1_data  [2];
    logic       y1_last  [2];
    logic       busy     [2];
    logic       cur_sel  [2];
    logic [7:0] pkt_cnt0 [2];
    logic [7:0] pkt_cnt1 [2];

    demux_stream_router #(.W(8), .RR_MODE(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .in_last(in_last[0]), .in_dest(in_dest[0]),
        .y0_valid(y0_valid[0]), .y0_ready(y0_ready[0]), .y0_data(y0_data[0]), .y0_last(y0_last[0]),
        .y1_valid(y1_valid[0]), .y1_ready(y1_ready[0]), .y1_data(y1_data[0]), .y1_last(y1_last[0]),
        .busy(busy[0]), .cur_sel(cur_sel[0]), .pkt_cnt0(pkt_cnt0[0]), .pkt_cnt1(pkt_cnt1[0])
    );

    demux_stream_router #(.W(8), .RR_MODE(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .in_last(in_last[1]), .in_dest(in_dest[1]),
        .y0_valid(y0_valid[1]), .y0_ready(y0_ready[1]), .y0_data(y0_data[1]), .y0_last(y0_last[1]),
        .y1_valid(y1_valid[1]), .y1_ready(y1_ready[1]), .y1_data(y1_data[1]), .y1_last(y1_last[1]),
        .busy(busy[1]), .cur_sel(cur_sel[1]), .pkt_cnt0(pkt_cnt0[1]), .pkt_cnt1(pkt_cnt1[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    int n_chk = 0;
    int n_err = 0;

    // Reference state: packet in progress, held beat, locked port, next round-robin port, counts.
    logic       m_pkt  [2];
    logic       m_ov   [2];
    logic       m_os   [2];
    logic [7:0] m_od   [2];
    logic       m_ol   [2];
    logic       m_lock [2];
    logic       m_rr   [2];
    logic [7:0] m_c0   [2];
    logic [7:0] m_c1   [2];
    logic       m_acc  [2];
    logic [8:0] sbq    [4][$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pkt[i] = 0; m_ov[i] = 0; m_os[i] = 0; m_od[i] = 0; m_ol[i] = 0;
            m_lock[i] = 0; m_rr[i] = 0; m_c0[i] = 0; m_c1[i] = 0; m_acc[i] = 0;
        end
        for (int k = 0; k < 4; k++) sbq[k].delete();
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            chk("y0_valid", 32'(y0_valid[i]), 32'(m_ov[i] & ~m_os[i]));
            chk("y1_valid", 32'(y1_valid[i]), 32'(m_ov[i] & m_os[i]));
            chk("y0_data",  32'(y0_data[i]),  32'(m_os[i] ? 8'h00 : m_od[i]));
            chk("y1_data",  32'(y1_data[i]),  32'(m_os[i] ? m_od[i] : 8'h00));
            chk("y0_last",  32'(y0_last[i]),  32'(~m_os[i] & m_ol[i]));
            chk("y1_last",  32'(y1_last[i]),  32'(m_os[i] & m_ol[i]));
            chk("busy",     32'(busy[i]),     32'(m_pkt[i] | m_ov[i]));
            chk("cur_sel",  32'(cur_sel[i]),  32'(m_lock[i]));
            chk("pkt_cnt0", 32'(pkt_cnt0[i]), 32'(m_c0[i]));
            chk("pkt_cnt1", 32'(pkt_cnt1[i]), 32'(m_c1[i]));
        end
    endtask

    // Inputs are already driven; evaluate this cycle, advance one clock, check registered outputs.
    task automatic cycle();
        logic       hold;
        logic       erdy;
        logic       d;
        logic [8:0] got;
        logic [8:0] want;
        int         idx;
        #1;
        for (int i = 0; i < 2; i++) begin
            hold = !m_ov[i] || (m_os[i] ? y1_ready[i] : y0_ready[i]);
            erdy = hold && (m_pkt[i] || en[i]);
            chk("in_ready", 32'(in_ready[i]), 32'(erdy));
            if (m_ov[i] && hold) begin
                idx = i * 2 + int'(m_os[i]);
                got = m_os[i] ? {y1_last[i], y1_data[i]} : {y0_last[i], y0_data[i]};
                if (sbq[idx].size() == 0) begin
                    chk("sb_underflow", 32'(sbq[idx].size()), 32'd1);
                end else begin
                    want = sbq[idx].pop_front();
                    chk("sb_beat", 32'(got), 32'(want));
                end
            end
            m_acc[i] = in_valid[i] && erdy;
            if (m_acc[i]) begin
                d = m_pkt[i] ? m_lock[i] : ((i == 1) ? m_rr[i] : in_dest[i]);
                sbq[i * 2 + int'(d)].push_back({in_last[i], in_data[i]});
                m_ov[i] = 1; m_os[i] = d; m_od[i] = in_data[i]; m_ol[i] = in_last[i];
                if (!m_pkt[i]) m_lock[i] = d;
                if (in_last[i]) begin
                    m_pkt[i] = 0;
                    if (d) m_c1[i] = m_c1[i] + 8'd1;
                    else   m_c0[i] = m_c0[i] + 8'd1;
                    if (i == 1) m_rr[i] = ~m_rr[i];
                end else begin
                    m_pkt[i] = 1;
                end
            end else if (hold) begin
                m_ov[i] = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input int i, input logic [7:0] d, input logic l, input logic ds);
        in_valid[i] = 1'b1; in_data[i] = d; in_last[i] = l; in_dest[i] = ds;
        m_acc[i] = 1'b0;
        for (int t = 0; t < 40 && !m_acc[i]; t++) cycle();
        if (!m_acc[i]) chk("send_timeout", 32'd0, 32'd1);
        in_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
        #1;
        check_outputs();
        for (int i = 0; i < 2; i++) chk("rst_in_ready", 32'(in_ready[i]), 32'(en[i]));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs();
    endtask

    task automatic drain();
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; y0_ready[i] = 1'b1; y1_ready[i] = 1'b1;
        end
        repeat (3) cycle();
        for (int k = 0; k < 4; k++) chk("sb_leftover", 32'(sbq[k].size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b1; in_valid[i] = 1'b0; in_data[i] = 8'h00; in_last[i] = 1'b0;
            in_dest[i] = 1'b0; y0_ready[i] = 1'b1; y1_ready[i] = 1'b1;
        end
        model_reset();
        @(negedge clk);
        do_reset();
        cycle();

        // Two 3-beat packets back to back, y0 then y1.
        send(0, 8'h11, 1'b0, 1'b0); send(0, 8'h12, 1'b0, 1'b1); send(0, 8'h13, 1'b1, 1'b0);
        send(0, 8'h21, 1'b0, 1'b1); send(0, 8'h22, 1'b0, 1'b0); send(0, 8'h23, 1'b1, 1'b1);
        drain();
        chk("two_pkt_cnt0", 32'(pkt_cnt0[0]), 32'd1);
        chk("two_pkt_cnt1", 32'(pkt_cnt1[0]), 32'd1);

        // Four-cycle stall on y0 mid-packet.
        send(0, 8'h31, 1'b0, 1'b0); send(0, 8'h32, 1'b0, 1'b0);
        y0_ready[0] = 1'b0;
        in_valid[0] = 1'b1; in_data[0] = 8'h33; in_last[0] = 1'b1;
        repeat (4) cycle();
        chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
        chk("bp_held",     32'(y0_data[0]),  32'h32);
        y0_ready[0] = 1'b1;
        send(0, 8'h33, 1'b1, 1'b0);
        drain();

        // Destination toggles and enable drops mid-packet; locked to y1 throughout.
        send(0, 8'h41, 1'b0, 1'b1);
        en[0] = 1'b0;
        send(0, 8'h42, 1'b0, 1'b0); send(0, 8'h43, 1'b0, 1'b1); send(0, 8'h44, 1'b1, 1'b0);
        in_valid[0] = 1'b1; in_data[0] = 8'h45; in_last[0] = 1'b1;
        cycle(); cycle();
        chk("en_low_idle_rdy", 32'(in_ready[0]), 32'd0);
        in_valid[0] = 1'b0;
        en[0] = 1'b1;
        drain();
        chk("en_drop_cnt1", 32'(pkt_cnt1[0]), 32'd2);

        // Round-robin instance ignores in_dest.
        for (int k = 0; k < 4; k++) send(1, 8'h51 + 8'(k), 1'b1, 1'b1);
        drain();
        chk("rr_cnt0", 32'(pkt_cnt0[1]), 32'd2);
        chk("rr_cnt1", 32'(pkt_cnt1[1]), 32'd2);

        // Counter wrap after 256 single-beat packets.
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 256; k++) send(0, 8'(k), 1'b1, 1'b1);
        drain();
        chk("wrap_cnt1", 32'(pkt_cnt1[0]), 32'd0);
        chk("wrap_cnt0", 32'(pkt_cnt0[0]), 32'd0);

        // Reset after two beats of a five-beat packet; next beat is a fresh first beat.
        send(0, 8'h61, 1'b1, 1'b0);
        send(0, 8'h62, 1'b0, 1'b1); send(0, 8'h63, 1'b0, 1'b1);
        do_reset();
        send(0, 8'h64, 1'b1, 1'b0);
        drain();
        chk("rst_mid_sel",  32'(cur_sel[0]),  32'd0);
        chk("rst_mid_cnt0", 32'(pkt_cnt0[0]), 32'd1);
        chk("rst_mid_cnt1", 32'(pkt_cnt1[0]), 32'd0);

        // Random traffic with random backpressure on both instances.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                en[i]       = ($urandom_range(0, 9) != 0);
                in_valid[i] = ($urandom_range(0, 3) != 0);
                in_data[i]  = 8'($urandom);
                in_last[i]  = ($urandom_range(0, 3) == 0);
                in_dest[i]  = 1'($urandom);
                y0_ready[i] = ($urandom_range(0, 3) != 0);
                y1_ready[i] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end
        for (int i = 0; i < 2; i++) en[i] = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
